simon_button_input: RTL and testbench
=====================================

Name: simon_button_input

Overview:
- Upstream stage of the Simon game core. Converts four raw, bouncing push-buttons into the one-cycle `playerPressed` strobe and 2-bit `playerNum` code that the game core consumes.
- Per button: 2-flop synchroniser, then counter-based debouncer.
- A press-arbitration FSM accepts exactly one clean press at a time and only while the core is listening. It ignores chords and bounce, and waits for full release before re-arming.

Parameters:
- DEBOUNCE_CYCLES, 20, consecutive cycles a synchronised input must differ from the debounced state before that state flips (minimum 2).
- CNT_W, 5, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (logic held in reset while 0).
- btn  input  4  raw asynchronous buttons, active-high; btn[i] encodes number i.
- enable  input  1  high when the game core is awaiting player input (driven from inverted simonTurn).
- playerNum  output  2  index of the last accepted button; holds between presses.
- playerPressed  output  1  one-cycle strobe, one per accepted press.
- chord  output  1  one-cycle strobe when two or more buttons become pressed together while enabled.

Behaviour:
- Reset values: playerNum=0, playerPressed=0, chord=0, sync flops=0, debounced state=0, counters=0, FSM=IDLE.
- Reset mid-operation: everything returns to reset values immediately. No strobe is emitted during reset or on the first cycle after release.
- Synchroniser: s1<=btn, s2<=s1 for each bit. Only s2 feeds the debouncer.
- Debouncer, per bit:
  - s2==deb: cnt<=0.
  - s2!=deb and cnt==DEBOUNCE_CYCLES-1: deb<=s2, cnt<=0.
  - otherwise: cnt<=cnt+1.
  - Any single-cycle return to the old value clears the count, so glitches shorter than DEBOUNCE_CYCLES never reach deb.
- FSM states:
  - IDLE: all deb bits 0, armed.
  - HELD: one or more deb bits 1, waiting for full release.
- IDLE transitions, evaluated on the deb vector:
  - Exactly one bit set and enable=1: playerNum<=index, playerPressed<=1 for one cycle, go HELD.
  - Two or more bits set and enable=1: chord<=1 for one cycle, playerNum unchanged, go HELD.
  - Any bit set and enable=0: no strobe, go HELD. A press made during Simon's turn is swallowed and never replayed later.
  - All bits 0: stay in IDLE.
- HELD transitions:
  - All deb bits 0: go IDLE.
  - Otherwise stay in HELD. Additional buttons pressed while HELD produce no strobe.
  - enable changes while HELD are ignored.
- Latency: playerPressed is high in the cycle after edge DEBOUNCE_CYCLES+3, counting from the first edge that samples btn high (2 sync edges + DEBOUNCE_CYCLES debounce edges + 1 registered output).
- Release must also persist for DEBOUNCE_CYCLES cycles before the FSM re-arms.
- Strobes are registered outputs, never combinational from btn.
- playerPressed and chord are never high in the same cycle.
- The counter saturates by construction and never wraps past DEBOUNCE_CYCLES-1.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset low for 3 cycles, then high, btn=0 → all outputs 0, no strobe for 20 cycles.
2. enable=1; btn=4'b0100 held 10 cycles, then released → playerPressed high for exactly one cycle, on the 7th edge after btn rise; playerNum=2 from that cycle and held after release.
3. enable=1; btn[1] toggles high/low every 2 cycles for 12 cycles, then held stable high → no strobe during bouncing; single strobe with playerNum=1 at 7 edges after the stable rise.
4. enable=1; btn=4'b1001 asserted in the same cycle → chord pulses once, playerPressed stays 0, playerNum keeps its prior value. After full release, btn=4'b1000 gives a strobe with playerNum=3.
5. enable=0; btn[0] pressed; enable raised to 1 while btn[0] is still held → no strobe. After release then re-press, strobe with playerNum=0.
6. btn[3] held, reset pulsed low 2 cycles mid-hold, reset returns with btn[3] still high → outputs 0 during reset; after release, strobe with playerNum=3 appears 7 edges later (fresh debounce); no duplicate strobe.

Source files
------------

// File: rtl/simon_button_input_if.sv
// Player-input bundle between the button front end and the Simon game core.
// The front end uses the slave view. The core side, or a bench, uses the master view.
interface simon_button_input_if;
    logic [3:0] btn;
    logic       enable;
    logic [1:0] playerNum;
    logic       playerPressed;
    logic       chord;

    modport master (
        output btn,
        output enable,
        input  playerNum,
        input  playerPressed,
        input  chord
    );

    modport slave (
        input  btn,
        input  enable,
        output playerNum,
        output playerPressed,
        output chord
    );
endinterface

// File: rtl/simon_button_input.sv
// Raw push-buttons to game-core strobes: sync, debounce, then single-press arbitration.
// A press is accepted only while the core listens, and only after a full release.
module simon_button_input #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int CNT_W           = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    simon_button_input_if.slave  bus
);

    typedef enum logic {IDLE, HELD} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       s1, s2, deb;
    logic [CNT_W-1:0] cnt [4];

    state_t     state, stateNext;
    logic [1:0] numQ, numNext;
    logic       pressQ, pressNext;
    logic       chordQ, chordNext;

    // NOTE: sequential state uses non-blocking assignments only. Every flop then
    // samples pre-edge values, so the s1 -> s2 -> deb chain delays exactly one cycle per stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1  <= '0;
            s2  <= '0;
            deb <= '0;
            // NOTE: the counter array is a handful of flops, not a RAM.
            // It is reset with everything else so a mid-hold reset forces a fresh debounce.
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            s1 <= bus.btn;
            s2 <= s1;
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            numQ   <= '0;
            pressQ <= 1'b0;
            chordQ <= 1'b0;
        end else begin
            state  <= stateNext;
            numQ   <= numNext;
            pressQ <= pressNext;
            chordQ <= chordNext;
        end
    end

    // NOTE: every output of this block gets a default first. No path can leave a
    // value unassigned, so no latch is inferred.
    always_comb begin
        stateNext = state;
        numNext   = numQ;
        pressNext = 1'b0;
        chordNext = 1'b0;
        case (state)
            IDLE: begin
                if (deb != 4'b0000) begin
                    stateNext = HELD;
                    if (bus.enable) begin
                        if ($onehot(deb)) begin
                            pressNext = 1'b1;
                            for (int i = 0; i < 4; i++)
                                if (deb[i]) numNext = 2'(i);
                        end else begin
                            chordNext = 1'b1;
                        end
                    end
                end
            end
            HELD: begin
                // Re-arm only once every button has been debounced back to released.
                if (deb == 4'b0000) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.playerNum     = numQ;
    assign bus.playerPressed = pressQ;
    assign bus.chord         = chordQ;

endmodule

// File: tb/tb_simon_button_input.sv
// Self-checking bench for simon_button_input. It uses directed scenarios plus randomized
// press/bounce/chord/reset traffic, all checked against a window-based behavioural model.
module tb_simon_button_input;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    simon_button_input_if bus ();

    simon_button_input #(.DEBOUNCE_CYCLES(N), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int compared = 0;
    int mismatched = 0;
    int cycleNo = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycleNo);
        end
    endtask

    // Model: a button counts as pressed once the delayed input has shown the opposite
    // level for N samples in a row. Arbitration is a single "armed" flag.
    logic [3:0] delayLine [$];
    logic [3:0] window [$];
    logic [3:0] mDeb;
    bit         armed;
    logic       expPress, expChord;
    logic [1:0] expNum;

    task automatic model_reset();
        delayLine = '{4'b0, 4'b0};
        window.delete();
        mDeb = '0;
        armed = 1'b1;
        expPress = 1'b0;
        expChord = 1'b0;
        expNum = '0;
    endtask

    task automatic model_edge(input logic [3:0] b, input logic en, input logic r);
        logic [3:0] arriving;
        bit allOpp;
        if (!r) begin
            model_reset();
            return;
        end
        expPress = armed && en && ($countones(mDeb) == 1);
        expChord = armed && en && ($countones(mDeb) >= 2);
        if (expPress)
            for (int i = 0; i < 4; i++) if (mDeb[i]) expNum = 2'(i);
        armed = (mDeb == 4'b0);
        arriving = delayLine.pop_front();
        delayLine.push_back(b);
        window.push_back(arriving);
        if (window.size() > N) void'(window.pop_front());
        if (window.size() == N) begin
            for (int i = 0; i < 4; i++) begin
                allOpp = 1'b1;
                for (int j = 0; j < N; j++) if (window[j][i] == mDeb[i]) allOpp = 1'b0;
                if (allOpp) mDeb[i] = ~mDeb[i];
            end
        end
    endtask

    task automatic cycle(input logic [3:0] b, input logic en, input logic r);
        @(negedge clk);
        bus.btn = b;
        bus.enable = en;
        reset = r;
        @(posedge clk);
        #1;
        cycleNo++;
        model_edge(b, en, r);
        check("playerPressed", 32'(bus.playerPressed), 32'(expPress));
        check("chord", 32'(bus.chord), 32'(expChord));
        check("playerNum", 32'(bus.playerNum), 32'(expNum));
        check("exclusive", 32'(bus.playerPressed & bus.chord), 32'd0);
    endtask

    task automatic idle(input int n, input logic en);
        for (int i = 0; i < n; i++) cycle(4'b0, en, 1'b1);
    endtask

    initial begin
        bus.btn = '0;
        bus.enable = 1'b0;
        model_reset();

        // 1: reset, then quiet
        for (int i = 0; i < 3; i++) cycle(4'b0, 1'b0, 1'b0);
        check("reset_num", 32'(bus.playerNum), 32'd0);
        idle(20, 1'b0);

        // 2: single press, exact latency, value held after release
        idle(2, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            cycle(4'b0100, 1'b1, 1'b1);
            if (i == 7) check("lat_press", 32'(bus.playerPressed), 32'd1);
        end
        idle(12, 1'b1);
        check("num_held", 32'(bus.playerNum), 32'd2);

        // 3: bounce on btn[1], then stable
        for (int i = 0; i < 12; i++) cycle(((i / 2) % 2 == 0) ? 4'b0010 : 4'b0000, 1'b1, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            cycle(4'b0010, 1'b1, 1'b1);
            if (i == 7) check("lat_bounce", 32'(bus.playerPressed), 32'd1);
        end
        idle(12, 1'b1);
        check("num_bounce", 32'(bus.playerNum), 32'd1);

        // 4: chord, then single button 3
        for (int i = 1; i <= 10; i++) begin
            cycle(4'b1001, 1'b1, 1'b1);
            if (i == 7) check("lat_chord", 32'(bus.chord), 32'd1);
        end
        check("num_after_chord", 32'(bus.playerNum), 32'd1);
        idle(12, 1'b1);
        for (int i = 0; i < 10; i++) cycle(4'b1000, 1'b1, 1'b1);
        check("num_after_b3", 32'(bus.playerNum), 32'd3);
        idle(12, 1'b1);

        // 5: press during Simon's turn is swallowed
        for (int i = 0; i < 8; i++) cycle(4'b0001, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(4'b0001, 1'b1, 1'b1);
        idle(12, 1'b1);
        check("num_swallowed", 32'(bus.playerNum), 32'd3);
        for (int i = 0; i < 10; i++) cycle(4'b0001, 1'b1, 1'b1);
        check("num_repress", 32'(bus.playerNum), 32'd0);
        idle(12, 1'b1);

        // 6: reset pulse mid-hold
        for (int i = 0; i < 10; i++) cycle(4'b1000, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) cycle(4'b1000, 1'b1, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            cycle(4'b1000, 1'b1, 1'b1);
            if (i == 7) check("lat_after_reset", 32'(bus.playerPressed), 32'd1);
        end
        idle(12, 1'b1);
        check("num_after_reset", 32'(bus.playerNum), 32'd3);

        // Randomized traffic
        for (int seg = 0; seg < 150; seg++) begin
            int unsigned mode, hold, bounce, gap;
            logic [3:0] target;
            logic en;
            mode   = $urandom_range(0, 9);
            en     = ($urandom_range(0, 3) != 0);
            hold   = $urandom_range(1, 12);
            bounce = $urandom_range(0, 6);
            gap    = $urandom_range(0, 10);
            if (mode < 5)      target = 4'b0001 << $urandom_range(0, 3);
            else if (mode < 8) target = 4'($urandom_range(0, 15));
            else               target = 4'b0000;
            for (int i = 0; i < int'(bounce); i++) cycle(target & 4'($urandom), en, 1'b1);
            for (int i = 0; i < int'(hold); i++) begin
                if ($urandom_range(0, 15) == 0) en = ~en;
                cycle(target, en, ($urandom_range(0, 79) != 0));
            end
            for (int i = 0; i < int'(bounce); i++) cycle(target & 4'($urandom), en, 1'b1);
            for (int i = 0; i < int'(gap); i++) cycle(4'b0, en, 1'b1);
        end
        idle(12, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
